writeback: RTL and testbench
============================

WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Parameter NREG, default 15, number of architectural registers (indices 0..14; index 15 = RNONE, never written).
REQ-002 Parameter W, default 64, register/data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 valid_in  input  1  one instruction commits this cycle.
REQ-006 icode  input  4  committed instruction code.
REQ-007 rA, rB  input  4 each  register specifiers of committed instruction.
REQ-008 cnd  input  1  condition flag from execute (used by cmovXX).
REQ-009 valE, valM  input  W each  execute result and memory-read result.
REQ-010 rd_addr_a, rd_addr_b  input  4 each  register-file read addresses (decode side).
REQ-011 rd_data_a, rd_data_b  output  W each  register contents at read addresses; 0 when address = 15.
REQ-012 stat  output  2  machine status: 2'b00 AOK, 2'b01 HLT, 2'b10 INS.
REQ-013 commit_cnt  output  32  count of instructions retired in AOK state.

Function
REQ-014 Destination decode SHALL be combinational: dstE = rB for icode 2 (only if cnd=1, else 15), 3, 6; dstE = 4 (%rsp) for icode 8, 9, A, B; dstE = 15 otherwise.
REQ-015 dstM SHALL be rA for icode 5 and B; 15 otherwise.
REQ-016 On rising clk with valid_in=1 and stat=AOK, reg[dstE] <= valE if dstE != 15, and reg[dstM] <= valM if dstM != 15.
REQ-017 When dstE == dstM != 15 in the same commit (popq %rsp), the valM write SHALL win.
REQ-018 Read ports SHALL be combinational from current register contents, no write-through bypass: a write at edge N is visible on rd_data only after edge N.
REQ-019 Status FSM states AOK, HLT, INS; reset state AOK.
REQ-020 AOK -> HLT on valid_in with icode 0; AOK -> INS on valid_in with icode > 4'hB; no register write for either.
REQ-021 HLT and INS SHALL be absorbing: valid_in ignored, no writes, commit_cnt frozen, until rst_n asserted.
REQ-022 commit_cnt SHALL increment by 1 on each valid_in in AOK with icode in 1..B (halt and invalid codes not counted), saturating at 32'hFFFF_FFFF.
REQ-023 valid_in=0 SHALL leave all state unchanged regardless of other inputs.

Reset
REQ-024 rst_n low SHALL immediately clear all registers to 0, stat to AOK, commit_cnt to 0, independent of clk.
REQ-025 Reset asserted mid-stream SHALL discard any same-cycle commit; first write after deassertion occurs on the first rising edge with rst_n high.

Structure
REQ-026 Shared package SHALL hold icode constants (IHALT..IPOPQ), RSP=4, RNONE=15, and the stat encodings/enum.
REQ-027 One sub-module, regfile (NREG x W storage, two write ports with port-M priority, two combinational read ports), is natural; the FSM, destination decode and counter stay in writeback.

Verification
REQ-028 Reset, then irmovq (icode 3, rB=2, valE=0x1234) -> reg2 = 0x1234 after the edge, commit_cnt=1, stat=AOK.
REQ-029 cmovXX (icode 2, rB=5, valE=7) with cnd=0 -> reg5 unchanged; with cnd=1 -> reg5 = 7.
REQ-030 popq %rsp (icode B, rA=4, valE=0x100, valM=0xABC) -> reg4 = 0xABC.
REQ-031 halt (icode 0) then OPq (icode 6, rB=1, valE=9) -> stat=HLT, reg1 unchanged, commit_cnt unchanged; rd_addr=15 -> rd_data=0.
REQ-032 icode 4'hD -> stat=INS, no writes; async rst_n pulse between clock edges -> registers 0, stat=AOK, commit_cnt=0 without a clock edge.

Source files
------------

// File: rtl/writeback_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | writeback_pkg : icode constants, register specifiers, status enum  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package writeback_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] RSP   = 4'h4;
   localparam logic [3:0] RNONE = 4'hF;

   typedef enum logic [1:0] {
      STAT_AOK = 2'b00,
      STAT_HLT = 2'b01,
      STAT_INS = 2'b10
   } stat_e;

endpackage
`default_nettype wire

// File: rtl/writeback_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | writeback_if : commit, register-read and status signals            |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface writeback_if #(
   parameter int W = 64
);
   logic         valid_in;
   logic [3:0]   icode;
   logic [3:0]   rA;
   logic [3:0]   rB;
   logic         cnd;
   logic [W-1:0] valE;
   logic [W-1:0] valM;
   logic [3:0]   rd_addr_a;
   logic [3:0]   rd_addr_b;
   logic [W-1:0] rd_data_a;
   logic [W-1:0] rd_data_b;
   logic [1:0]   stat;
   logic [31:0]  commit_cnt;

   modport master (
      output valid_in, icode, rA, rB, cnd, valE, valM, rd_addr_a, rd_addr_b,
      input  rd_data_a, rd_data_b, stat, commit_cnt
   );

   modport slave (
      input  valid_in, icode, rA, rB, cnd, valE, valM, rd_addr_a, rd_addr_b,
      output rd_data_a, rd_data_b, stat, commit_cnt
   );
endinterface
`default_nettype wire

// File: rtl/writeback_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | writeback_regfile : NREG x W registers, 2 write ports (M wins),    |
// | 2 combinational read ports; rev 1.0                                |
// +--------------------------------------------------------------------+
module writeback_regfile #(
   parameter int NREG = 15,
   parameter int W    = 64
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   input  wire logic         we_e_i,
   input  wire logic [3:0]   waddr_e_i,
   input  wire logic [W-1:0] wdata_e_i,
   input  wire logic         we_m_i,
   input  wire logic [3:0]   waddr_m_i,
   input  wire logic [W-1:0] wdata_m_i,
   input  wire logic [3:0]   raddr_a_i,
   input  wire logic [3:0]   raddr_b_i,
   output logic      [W-1:0] rdata_a_o,
   output logic      [W-1:0] rdata_b_o
);

   logic [W-1:0] regs_q [NREG];

   // Port M is written last so it overrides port E on a shared index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         if (we_e_i && ({28'd0, waddr_e_i} < 32'(NREG))) begin
            regs_q[waddr_e_i] <= wdata_e_i;
         end
         if (we_m_i && ({28'd0, waddr_m_i} < 32'(NREG))) begin
            regs_q[waddr_m_i] <= wdata_m_i;
         end
      end
   end

   assign rdata_a_o = ({28'd0, raddr_a_i} < 32'(NREG)) ? regs_q[raddr_a_i] : '0;
   assign rdata_b_o = ({28'd0, raddr_b_i} < 32'(NREG)) ? regs_q[raddr_b_i] : '0;

endmodule
`default_nettype wire

// File: rtl/writeback.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | writeback : destination decode, status FSM, retire counter         |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module writeback
   import writeback_pkg::*;
#(
   parameter int NREG = 15,
   parameter int W    = 64
) (
   input  wire logic clk,
   input  wire logic rst_n,
   writeback_if.slave bus
);

   stat_e       state_q, state_d;
   logic [31:0] commit_cnt_q, commit_cnt_d;
   logic [3:0]  w_dst_e, w_dst_m;
   logic        w_accept, w_retire;

   assign w_accept = bus.valid_in && (state_q == STAT_AOK);
   assign w_retire = w_accept && (bus.icode != IHALT) && (bus.icode <= IPOPQ);

   always_comb begin
      w_dst_e = RNONE;
      w_dst_m = RNONE;
      case (bus.icode)
         IRRMOVQ:                     w_dst_e = bus.cnd ? bus.rB : RNONE;
         IIRMOVQ, IOPQ:               w_dst_e = bus.rB;
         ICALL, IRET, IPUSHQ, IPOPQ:  w_dst_e = RSP;
         default:                     w_dst_e = RNONE;
      endcase
      if (bus.icode == IMRMOVQ || bus.icode == IPOPQ) begin
         w_dst_m = bus.rA;
      end
   end

   always_comb begin
      state_d      = state_q;
      commit_cnt_d = commit_cnt_q;
      if (w_accept) begin
         if (bus.icode == IHALT) begin
            state_d = STAT_HLT;
         end else if (bus.icode > IPOPQ) begin
            state_d = STAT_INS;
         end
      end
      if (w_retire && (commit_cnt_q != 32'hFFFF_FFFF)) begin
         commit_cnt_d = commit_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= STAT_AOK;
         commit_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         commit_cnt_q <= commit_cnt_d;
      end
   end

   writeback_regfile #(
      .NREG (NREG),
      .W    (W)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_e_i    (w_retire && (w_dst_e != RNONE)),
      .waddr_e_i (w_dst_e),
      .wdata_e_i (bus.valE),
      .we_m_i    (w_retire && (w_dst_m != RNONE)),
      .waddr_m_i (w_dst_m),
      .wdata_m_i (bus.valM),
      .raddr_a_i (bus.rd_addr_a),
      .raddr_b_i (bus.rd_addr_b),
      .rdata_a_o (bus.rd_data_a),
      .rdata_b_o (bus.rd_data_b)
   );

   assign bus.stat       = state_q;
   assign bus.commit_cnt = commit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_writeback : randomized + directed bench against a commit model  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_writeback;

   logic clk;
   logic rst_n;
   int   tests_run;
   int   tests_failed;

   writeback_if #(.W(64)) bus ();

   writeback #(.NREG(15), .W(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural model: 16 slots, slot 15 always reads as zero.
   logic [63:0] m_regs [16];
   logic [1:0]  m_stat;
   logic [31:0] m_cnt;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_stat = 2'b00;
      m_cnt  = '0;
   endtask

   task automatic model_wr(input logic [3:0] r, input logic [63:0] v);
      if (r != 4'hF) m_regs[r] = v;
   endtask

   task automatic model_step(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                             input logic c, input logic [63:0] ve, input logic [63:0] vm);
      if (m_stat != 2'b00) return;
      if (ic == 4'h0) begin m_stat = 2'b01; return; end
      if (ic > 4'hB) begin m_stat = 2'b10; return; end
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      case (ic)
         4'h2:             if (c) model_wr(rb, ve);
         4'h3, 4'h6:       model_wr(rb, ve);
         4'h5:             model_wr(ra, vm);
         4'h8, 4'h9, 4'hA: model_wr(4'h4, ve);
         4'hB: begin model_wr(4'h4, ve); model_wr(ra, vm); end
         default: ;
      endcase
   endtask

   task automatic commit(input logic v, input logic [3:0] ic, input logic [3:0] ra,
                         input logic [3:0] rb, input logic c,
                         input logic [63:0] ve, input logic [63:0] vm);
      @(negedge clk);
      bus.valid_in = v; bus.icode = ic; bus.rA = ra; bus.rB = rb;
      bus.cnd = c; bus.valE = ve; bus.valM = vm;
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      if (v) model_step(ic, ra, rb, c, ve, vm);
   endtask

   task automatic peek(input logic [3:0] a, input logic [3:0] b,
                       output logic [63:0] da, output logic [63:0] db);
      bus.rd_addr_a = a;
      bus.rd_addr_b = b;
      #1;
      da = bus.rd_data_a;
      db = bus.rd_data_b;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      logic [63:0] da, db;
      do_reset();
      tests_run++;
      if (bus.stat !== 2'b00) begin tests_failed++; $display("FAIL reset_stat got=%0h exp=0", bus.stat); end
      tests_run++;
      if (bus.commit_cnt !== 32'd0) begin tests_failed++; $display("FAIL reset_cnt got=%0h exp=0", bus.commit_cnt); end
      for (int r = 0; r < 16; r++) begin
         peek(4'(r), 4'(15 - r), da, db);
         tests_run++;
         if (da !== 64'd0 || db !== 64'd0) begin
            tests_failed++; $display("FAIL reset_reg%0d got=%0h/%0h exp=0", r, da, db);
         end
      end
   endtask

   task automatic test_irmovq();
      @(negedge clk);
      bus.valid_in = 1'b1; bus.icode = 4'h3; bus.rA = 4'hF; bus.rB = 4'h2;
      bus.cnd = 1'b0; bus.valE = 64'h1234; bus.valM = 64'hDEAD;
      bus.rd_addr_a = 4'h2;
      #1;
      tests_run++;
      if (bus.rd_data_a !== 64'd0) begin tests_failed++; $display("FAIL irmovq_nobypass got=%0h exp=0", bus.rd_data_a); end
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      model_step(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, 64'hDEAD);
      tests_run++;
      if (bus.rd_data_a !== 64'h1234) begin tests_failed++; $display("FAIL irmovq_reg2 got=%0h exp=1234", bus.rd_data_a); end
      tests_run++;
      if (bus.commit_cnt !== 32'd1) begin tests_failed++; $display("FAIL irmovq_cnt got=%0d exp=1", bus.commit_cnt); end
      tests_run++;
      if (bus.stat !== 2'b00) begin tests_failed++; $display("FAIL irmovq_stat got=%0h exp=0", bus.stat); end
   endtask

   task automatic test_cmov();
      logic [63:0] da, db;
      commit(1'b1, 4'h2, 4'h0, 4'h5, 1'b0, 64'd7, 64'd0);
      peek(4'h5, 4'h5, da, db);
      tests_run++;
      if (da !== 64'd0) begin tests_failed++; $display("FAIL cmov_cnd0 got=%0h exp=0", da); end
      commit(1'b1, 4'h2, 4'h0, 4'h5, 1'b1, 64'd7, 64'd0);
      peek(4'h5, 4'h5, da, db);
      tests_run++;
      if (db !== 64'd7) begin tests_failed++; $display("FAIL cmov_cnd1 got=%0h exp=7", db); end
      tests_run++;
      if (bus.commit_cnt !== m_cnt) begin tests_failed++; $display("FAIL cmov_cnt got=%0d exp=%0d", bus.commit_cnt, m_cnt); end
   endtask

   task automatic test_popq_rsp();
      logic [63:0] da, db;
      commit(1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'hABC);
      peek(4'h4, 4'h2, da, db);
      tests_run++;
      if (da !== 64'hABC) begin tests_failed++; $display("FAIL popq_rsp got=%0h exp=abc", da); end
      tests_run++;
      if (db !== m_regs[2]) begin tests_failed++; $display("FAIL popq_other got=%0h exp=%0h", db, m_regs[2]); end
   endtask

   task automatic test_halt();
      logic [63:0] da, db;
      logic [31:0] cnt_before;
      cnt_before = m_cnt;
      commit(1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 64'h55, 64'h66);
      commit(1'b1, 4'h6, 4'h0, 4'h1, 1'b0, 64'd9, 64'd0);
      tests_run++;
      if (bus.stat !== 2'b01) begin tests_failed++; $display("FAIL halt_stat got=%0h exp=1", bus.stat); end
      peek(4'h1, 4'hF, da, db);
      tests_run++;
      if (da !== 64'd0) begin tests_failed++; $display("FAIL halt_reg1 got=%0h exp=0", da); end
      tests_run++;
      if (bus.commit_cnt !== cnt_before) begin tests_failed++; $display("FAIL halt_cnt got=%0d exp=%0d", bus.commit_cnt, cnt_before); end
      tests_run++;
      if (db !== 64'd0) begin tests_failed++; $display("FAIL rnone_read_b got=%0h exp=0", db); end
      peek(4'hF, 4'h4, da, db);
      tests_run++;
      if (da !== 64'd0) begin tests_failed++; $display("FAIL rnone_read_a got=%0h exp=0", da); end
   endtask

   task automatic test_invalid_async();
      logic [63:0] da, db;
      do_reset();
      commit(1'b1, 4'h3, 4'h0, 4'h7, 1'b0, 64'hCAFE, 64'd0);
      commit(1'b1, 4'hD, 4'h7, 4'h7, 1'b1, 64'h1111, 64'h2222);
      tests_run++;
      if (bus.stat !== 2'b10) begin tests_failed++; $display("FAIL ins_stat got=%0h exp=2", bus.stat); end
      for (int r = 0; r < 16; r++) begin
         peek(4'(r), 4'(r), da, db);
         tests_run++;
         if (da !== m_regs[r]) begin tests_failed++; $display("FAIL ins_reg%0d got=%0h exp=%0h", r, da, m_regs[r]); end
      end
      // Asynchronous pulse strictly between edges.
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      tests_run++;
      if (bus.stat !== 2'b00 || bus.commit_cnt !== 32'd0) begin
         tests_failed++; $display("FAIL async_rst stat/cnt got=%0h/%0d exp=0/0", bus.stat, bus.commit_cnt);
      end
      peek(4'h7, 4'h7, da, db);
      tests_run++;
      if (da !== 64'd0) begin tests_failed++; $display("FAIL async_rst_reg7 got=%0h exp=0", da); end
      // Commit presented while reset held is discarded.
      @(negedge clk);
      bus.valid_in = 1'b1; bus.icode = 4'h3; bus.rB = 4'h3; bus.valE = 64'h77;
      bus.rd_addr_a = 4'h3;
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.rd_data_a !== 64'd0) begin tests_failed++; $display("FAIL rst_discard got=%0h exp=0", bus.rd_data_a); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus.valid_in = 1'b0;
      model_step(4'h3, bus.rA, 4'h3, bus.cnd, 64'h77, bus.valM);
      tests_run++;
      if (bus.rd_data_a !== 64'h77) begin tests_failed++; $display("FAIL rst_first_edge got=%0h exp=77", bus.rd_data_a); end
   endtask

   task automatic test_valid_low();
      logic [63:0] da, db;
      for (int i = 0; i < 20; i++) begin
         commit(1'b0, 4'($urandom_range(1, 11)), 4'($urandom), 4'($urandom), 1'b1,
                {$urandom, $urandom}, {$urandom, $urandom});
      end
      tests_run++;
      if (bus.commit_cnt !== m_cnt || bus.stat !== m_stat) begin
         tests_failed++; $display("FAIL idle_state got=%0d/%0h exp=%0d/%0h", bus.commit_cnt, bus.stat, m_cnt, m_stat);
      end
      for (int r = 0; r < 16; r++) begin
         peek(4'(r), 4'(r), da, db);
         tests_run++;
         if (db !== m_regs[r]) begin tests_failed++; $display("FAIL idle_reg%0d got=%0h exp=%0h", r, db, m_regs[r]); end
      end
   endtask

   task automatic test_random();
      logic [63:0] da, db;
      logic [3:0]  ic, ra, rb, pa, pb;
      int          sel, stuck;
      stuck = 0;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         sel = $urandom_range(0, 99);
         if (sel < 3)      ic = 4'h0;
         else if (sel < 6) ic = 4'($urandom_range(12, 15));
         else              ic = 4'($urandom_range(1, 11));
         ra = 4'($urandom);
         rb = 4'($urandom);
         commit(($urandom_range(0, 3) != 0), ic, ra, rb, 1'($urandom),
                {$urandom, $urandom}, {$urandom, $urandom});
         pa = 4'($urandom);
         pb = 4'($urandom);
         peek(pa, pb, da, db);
         tests_run++;
         if (bus.stat !== m_stat || bus.commit_cnt !== m_cnt) begin
            tests_failed++;
            $display("FAIL rand%0d stat/cnt got=%0h/%0d exp=%0h/%0d", i, bus.stat, bus.commit_cnt, m_stat, m_cnt);
         end
         tests_run++;
         if (da !== m_regs[pa] || db !== m_regs[pb]) begin
            tests_failed++;
            $display("FAIL rand%0d regs r%0d=%0h r%0d=%0h exp=%0h/%0h", i, pa, da, pb, db, m_regs[pa], m_regs[pb]);
         end
         if (m_stat != 2'b00) stuck++;
         if (stuck > 3) begin
            stuck = 0;
            do_reset();
         end
      end
   endtask

   initial begin
      tests_run     = 0;
      tests_failed  = 0;
      rst_n         = 1'b0;
      bus.valid_in  = 1'b0;
      bus.icode     = 4'h0;
      bus.rA        = 4'hF;
      bus.rB        = 4'hF;
      bus.cnd       = 1'b0;
      bus.valE      = '0;
      bus.valM      = '0;
      bus.rd_addr_a = 4'h0;
      bus.rd_addr_b = 4'h0;
      model_reset();
      repeat (2) @(posedge clk);
      test_reset();
      test_irmovq();
      test_cmov();
      test_popq_rsp();
      test_halt();
      test_invalid_async();
      test_valid_low();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
